// File: rtl/ddr4_pkg.sv
// Shared types and constants for the DDR4 request scheduler: FSM states,
// bank-group bit positions, queue entry layout and default sizing.
package ddr4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } state_t;

  localparam int BG_MSB      = 31;
  localparam int BG_LSB      = 30;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [15:0] wdata;
  } req_t;

  localparam int ENTRY_W = $bits(req_t);

endpackage

// File: rtl/ddr4_req_fifo.sv
// Request queue: DEPTH-entry FIFO, head visible combinationally, 1-cycle push-to-pop.
// Pushes while full and pops while empty are ignored; count is the registered occupancy.
module ddr4_req_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 49
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/ddr4_req_scheduler.sv
// Queues host requests and issues them one at a time to the DDR4 controller, one response pulse each.
// Issue 1 cycle after an entry is queued; req_ready drops when full; optional watchdog via DDR4_REQ_TIMEOUT_EN.
module ddr4_req_scheduler
  import ddr4_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [31:0]            req_addr,
  input  logic [15:0]            req_wdata,
  output logic                   rsp_valid,
  output logic                   rsp_write,
  output logic [15:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [31:0]            mc_addr,
  output logic [15:0]            mc_wdata,
  output logic                   mc_read_en,
  output logic                   mc_write_en,
  output logic [1:0]             mc_bg_en,
  input  logic                   mc_ready,
  input  logic [15:0]            mc_rdata,
  output logic [$clog2(DEPTH):0] count
);

  state_t      state, state_nxt;
  req_t        head;
  req_t        din;
  logic        full, empty;
  logic        pop;
  logic        done_ok;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic [15:0] rdata_q;

  assign din       = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = !rst && !full;

  ddr4_req_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid && req_ready),
    .din   (din),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef DDR4_REQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;
  logic            wd_hit;
  logic            err_q;

  assign wd_hit = (state == WAIT_ACK || state == WAIT_DONE) && (wd == WD_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && mc_ready) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:     state_nxt = WAIT_ACK;
      WAIT_ACK:  if (!mc_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (mc_ready) begin
          done_ok   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
`ifdef DDR4_REQ_TIMEOUT_EN
    // Watchdog wins over a completion arriving on the same edge.
    if (wd_hit) begin
      done_ok   = 1'b0;
      state_nxt = RESP;
    end
`endif
  end

  // rdata_q is zeroed on issue so a timed-out command reports 0 without extra muxing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        cmd_write <= head.write;
        cmd_addr  <= head.addr;
        cmd_wdata <= head.wdata;
        rdata_q   <= '0;
      end
      if (done_ok) rdata_q <= cmd_write ? 16'h0000 : mc_rdata;
    end
  end

`ifdef DDR4_REQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == WAIT_ACK || state == WAIT_DONE) wd <= wd + WD_W'(1);
      else                                         wd <= '0;
      if (pop)         err_q <= 1'b0;
      else if (wd_hit) err_q <= 1'b1;
    end
  end

  assign rsp_err = (state == RESP) && err_q;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
  assign rsp_err        = 1'b0;
`endif

  assign mc_addr     = cmd_addr;
  assign mc_wdata    = cmd_wdata;
  assign mc_bg_en    = cmd_addr[BG_MSB:BG_LSB];
  assign mc_read_en  = (state == ISSUE) && !cmd_write;
  assign mc_write_en = (state == ISSUE) && cmd_write;
  assign rsp_valid   = (state == RESP);
  assign rsp_write   = (state == RESP) && cmd_write;
  assign rsp_rdata   = (state == RESP) ? rdata_q : 16'h0000;

endmodule

// File: tb/tb_ddr4_req_scheduler.sv
// Bench for ddr4_req_scheduler: queue/scoreboard reference model plus a scripted controller
// responder; directed scenarios and a randomized burst run from one initial block.
module tb_ddr4_req_scheduler;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [15:0] rsp_rdata;
  logic [31:0] mc_addr;
  logic [15:0] mc_wdata;
  logic        mc_read_en, mc_write_en, mc_ready;
  logic [1:0]  mc_bg_en;
  logic [15:0] mc_rdata;
  logic [3:0]  count;

  always #5 clk = ~clk;

  ddr4_req_scheduler #(.DEPTH(DEPTH), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_read_en(mc_read_en), .mc_write_en(mc_write_en),
    .mc_bg_en(mc_bg_en), .mc_ready(mc_ready), .mc_rdata(mc_rdata), .count(count)
  );

  typedef struct { logic w; logic [31:0] a; logic [15:0] d; } req_m;
  typedef struct { logic w; logic [15:0] rd; logic err; } rsp_m;

  req_m        iss_q[$];
  rsp_m        rsp_q[$];
  int          model_cnt = 0, pend_push = 0;
  int          errors = 0, checks = 0;
  int          n_strobe = 0, n_rsp = 0, cyc = 0;
  int          last_strobe_cyc = 0, last_rsp_cyc = 0;
  logic        last_rsp_write;
  logic [15:0] last_rsp_rdata;
  int          r_phase = 0, r_cnt = 0, d1_fix = 0, d2_fix = 0;
  bit          r_auto = 1'b1, to_mode = 1'b0;
  logic [15:0] rdata_fix = 16'h0000;

  function automatic logic [15:0] rd_of(logic [31:0] a);
    return (rdata_fix != 16'h0000) ? rdata_fix : (a[15:0] ^ 16'h5A5A);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, update the model, then drive the responder.
  task automatic step();
    req_m e;
    rsp_m r;
    @(posedge clk);
    #1;
    cyc++;
    model_cnt += pend_push;
    pend_push = 0;
    if (r_phase == 1) begin
      if (r_cnt <= 1) begin
        mc_ready = 1'b0;
        r_phase  = 2;
        r_cnt    = (d2_fix > 0) ? d2_fix : int'($urandom_range(1, 4));
      end else r_cnt--;
    end else if (r_phase == 2) begin
      if (r_cnt <= 1) begin
        mc_rdata = rd_of(mc_addr);
        mc_ready = 1'b1;
        r_phase  = 0;
      end else r_cnt--;
    end
    if (!rst) begin
      chk("strobe_excl", mc_read_en & mc_write_en, 0);
      if (mc_read_en || mc_write_en) begin
        n_strobe++;
        last_strobe_cyc = cyc;
        chk("strobe_has_req", iss_q.size() != 0, 1);
        chk("one_outstanding", rsp_q.size(), 0);
        if (iss_q.size() != 0) begin
          e = iss_q.pop_front();
          model_cnt--;
          chk("strobe_kind", mc_write_en, e.w);
          chk("mc_addr", mc_addr, e.a);
          chk("mc_bg_en", mc_bg_en, e.a[31:30]);
          if (e.w) chk("mc_wdata", mc_wdata, e.d);
          rsp_q.push_back('{e.w, (e.w || to_mode) ? 16'h0000 : rd_of(e.a), to_mode});
        end
        if (r_auto) begin
          r_phase = 1;
          r_cnt   = (d1_fix > 0) ? d1_fix : int'($urandom_range(1, 3));
        end
      end
      if (rsp_valid) begin
        n_rsp++;
        last_rsp_cyc   = cyc;
        last_rsp_write = rsp_write;
        last_rsp_rdata = rsp_rdata;
        chk("rsp_expected", rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          chk("rsp_write", rsp_write, r.w);
          chk("rsp_rdata", rsp_rdata, r.rd);
          chk("rsp_err", rsp_err, r.err);
        end
      end
      chk("count", count, model_cnt);
    end
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    chk("req_ready", req_ready, model_cnt < DEPTH);
    if (model_cnt < DEPTH) begin
      iss_q.push_back('{w, a, d});
      pend_push = 1;
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic push_rand();
    push(1'($urandom_range(0, 1)), $urandom(), 16'($urandom()));
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((iss_q.size() != 0 || rsp_q.size() != 0 || r_phase != 0) && k < bound) begin
      step();
      k++;
    end
    chk("drain_in_time", k < bound, 1);
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s0, r0, k, s_cyc;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    mc_ready = 1'b1; mc_rdata = '0;

    repeat (2) step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_outputs", {rsp_valid, rsp_write, rsp_err, rsp_rdata, mc_read_en, mc_write_en, mc_bg_en}, 0);
    chk("rst_mc_addr", mc_addr, 0);
    chk("rst_mc_wdata", mc_wdata, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", req_ready, 1);

    // Single read with scripted handshake timing.
    d1_fix = 2; d2_fix = 3; rdata_fix = 16'hBEEF;
    s0 = n_strobe; r0 = n_rsp;
    push(1'b0, 32'h8000_0010, 16'h0);
    step();
    chk("read_latency", mc_read_en, 1);
    chk("read_bg", mc_bg_en, 2);
    drain(100);
    chk("read_pulses", n_strobe - s0, 1);
    chk("read_rsps", n_rsp - r0, 1);
    chk("read_rdata", last_rsp_rdata, 16'hBEEF);
    chk("read_rsp_write", last_rsp_write, 0);
    rdata_fix = 16'h0000;

    // Single write.
    s0 = n_strobe;
    push(1'b1, 32'hC000_0000, 16'h1234);
    step();
    chk("write_strobe", mc_write_en, 1);
    chk("write_wdata", mc_wdata, 16'h1234);
    chk("write_bg", mc_bg_en, 3);
    drain(100);
    chk("write_rsp_write", last_rsp_write, 1);
    chk("write_rsp_rdata", last_rsp_rdata, 0);
    d1_fix = 0; d2_fix = 0;

    // Randomized traffic with random gaps and handshake delays.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) step();
      else push_rand();
    end
    drain(2000);

    // Simultaneous push and pop at count 3.
    mc_ready = 1'b0;
    repeat (3) push_rand();
    chk("pre_pp3_cnt", count, 3);
    mc_ready = 1'b1;
    push_rand();
    chk("pushpop_cnt3", count, 3);
    drain(500);

    // Fill with the controller busy, then push/pop at full.
    mc_ready = 1'b0;
    r0 = n_rsp;
    repeat (9) push_rand();
    chk("fill_cnt", count, 8);
    chk("fill_ready", req_ready, 0);
    mc_ready = 1'b1;
    push_rand();
    chk("pushpop_full_cnt", count, 7);
    drain(1000);
    chk("fill_rsps", n_rsp - r0, 8);

    // Reset while a command sits in WAIT_DONE with three entries queued.
    d1_fix = 1; d2_fix = 20;
    repeat (4) push_rand();
    k = 0;
    while (mc_ready && k < 50) begin step(); k++; end
    chk("reached_wait", k < 50, 1);
    step();
    chk("pre_reset_cnt", count, 3);
    rst = 1'b1;
    step();
    chk("mid_rst_cnt", count, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_outputs", {rsp_valid, rsp_write, rsp_err, rsp_rdata, mc_read_en, mc_write_en, mc_bg_en}, 0);
    chk("mid_rst_mc_addr", mc_addr, 0);
    iss_q.delete(); rsp_q.delete(); model_cnt = 0; pend_push = 0; r_phase = 0;
    mc_ready = 1'b1; rst = 1'b0;
    s0 = n_strobe; r0 = n_rsp;
    repeat (10) step();
    chk("post_rst_strobes", n_strobe - s0, 0);
    chk("post_rst_rsps", n_rsp - r0, 0);
    chk("post_rst_ready", req_ready, 1);
    d1_fix = 0; d2_fix = 0;

`ifdef DDR4_REQ_TIMEOUT_EN
    // Controller never drops mc_ready: both commands must time out in order.
    r_auto = 1'b0; to_mode = 1'b1;
    s0 = n_strobe; r0 = n_rsp;
    push(1'b0, 32'h4000_0100, 16'h0);
    push(1'b0, 32'h0000_0200, 16'h0);
    s_cyc = last_strobe_cyc;
    k = 0;
    while (n_rsp == r0 && k < 200) begin step(); k++; end
    chk("timeout_seen", n_rsp - r0, 1);
    chk("timeout_latency", last_rsp_cyc - s_cyc, 65);
    k = 0;
    while (n_rsp < r0 + 2 && k < 200) begin step(); k++; end
    chk("timeout_next_issue", n_strobe - s0, 2);
    chk("timeout_second_rsp", n_rsp - r0, 2);
    step();
    r_auto = 1'b1; to_mode = 1'b0;
`else
    s_cyc = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
